// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared constants and enumerations for the MIDI note sequencer
package midi_pkg;

    // Upper nibble of the channel-voice status bytes we act on
    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;

    // Channel-mode controllers that silence everything
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    // Bytes at or above this value are system realtime and never disturb parsing
    localparam logic [7:0] RT_THRESHOLD = 8'hF8;

    typedef enum logic [1:0] {
        P_IDLE     = 2'd0,
        P_WAIT_KEY = 2'd1,
        P_WAIT_VAL = 2'd2
    } parser_state_t;

    typedef enum logic [1:0] {
        CMD_ON  = 2'd0,
        CMD_OFF = 2'd1,
        CMD_CC  = 2'd2
    } cmd_t;

endpackage

// File: rtl/note_stack.sv
// rtl/note_stack.sv - last-note-priority key stack with single-cycle push/remove/evict/clear
module note_stack #(
    parameter int STACK_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       remove,
    input  logic       clear,
    input  logic [6:0] key,
    output logic [6:0] top,
    output logic [4:0] count,
    output logic       full,
    output logic       hit
);

    // Entry 0 is the oldest key; entry count-1 is the most recent (the top)
    logic [6:0]             entries   [STACK_DEPTH];
    logic [6:0]             entries_n [STACK_DEPTH];
    logic [4:0]             count_n;
    logic [STACK_DEPTH-1:0] match;
    logic [4:0]             hit_idx;
    logic                   drop;
    logic [4:0]             drop_idx;
    logic [4:0]             kept;

    // Compare the incoming key against every live entry at once
    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int j = 0; j < STACK_DEPTH; j++) begin
            match[j] = (5'(j) < count) && (entries[j] == key);
            if (match[j]) begin
                hit_idx = 5'(j);
            end
        end
    end

    assign hit  = |match;
    assign full = (count == 5'(STACK_DEPTH));

    // Select the most recent entry; zero when empty
    always_comb begin
        top = '0;
        for (int j = 0; j < STACK_DEPTH; j++) begin
            if (5'(j) + 5'd1 == count) begin
                top = entries[j];
            end
        end
    end

    // Remove-and-compact (a held key, or the oldest one when full), then optionally append
    always_comb begin
        drop     = 1'b0;
        drop_idx = '0;
        if ((push || remove) && hit) begin
            drop     = 1'b1;
            drop_idx = hit_idx;
        end else if (push && full) begin
            drop     = 1'b1;
            drop_idx = '0;
        end
        kept = count - {4'd0, drop};

        for (int j = 0; j < STACK_DEPTH; j++) begin
            entries_n[j] = entries[j];
        end
        if (drop) begin
            for (int j = 0; j < STACK_DEPTH - 1; j++) begin
                if (5'(j) >= drop_idx) begin
                    entries_n[j] = entries[j+1];
                end
            end
        end

        count_n = count;
        if (clear) begin
            count_n = '0;
        end else if (push) begin
            for (int j = 0; j < STACK_DEPTH; j++) begin
                if (5'(j) == kept) begin
                    entries_n[j] = key;
                end
            end
            count_n = kept + 5'd1;
        end else if (remove) begin
            count_n = kept;
        end
    end

    // Stack storage and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int j = 0; j < STACK_DEPTH; j++) begin
                entries[j] <= '0;
            end
        end else begin
            count <= count_n;
            for (int j = 0; j < STACK_DEPTH; j++) begin
                entries[j] <= entries_n[j];
            end
        end
    end

endmodule

// File: rtl/midi_note_sequencer.sv
// rtl/midi_note_sequencer.sv - MIDI parser, command decode and monophonic note scheduler
module midi_note_sequencer
    import midi_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int CHANNEL     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] midi_data,
    input  logic       midi_valid,
    output logic [7:0] note_data,
    output logic       note_valid,
    output logic       gate,
    output logic [4:0] held_count,
    output logic       overflow
);

    parser_state_t state, state_n;
    cmd_t          cmd, cmd_n;
    logic [6:0]    key_reg, key_n;
    logic          exec;

    logic          push, remove, clear;
    logic [6:0]    top;
    logic          full, hit;

    logic          is_realtime;
    logic          chan_match;

    assign is_realtime = (midi_data >= RT_THRESHOLD);
    assign chan_match  = (midi_data[3:0] == 4'(CHANNEL));

    // Parser state, running-status command and pending key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= P_IDLE;
            cmd     <= CMD_ON;
            key_reg <= '0;
        end else begin
            state   <= state_n;
            cmd     <= cmd_n;
            key_reg <= key_n;
        end
    end

    // Byte classification and parser transitions; exec marks a completed message
    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        key_n   = key_reg;
        exec    = 1'b0;
        if (midi_valid) begin
            if (midi_data[7]) begin
                if (!is_realtime) begin
                    state_n = P_IDLE;
                    if (chan_match) begin
                        case (midi_data[7:4])
                            ST_NOTE_OFF: begin cmd_n = CMD_OFF; state_n = P_WAIT_KEY; end
                            ST_NOTE_ON:  begin cmd_n = CMD_ON;  state_n = P_WAIT_KEY; end
                            ST_CC:       begin cmd_n = CMD_CC;  state_n = P_WAIT_KEY; end
                            default:     state_n = P_IDLE;
                        endcase
                    end
                end
            end else begin
                case (state)
                    P_WAIT_KEY: begin
                        key_n   = midi_data[6:0];
                        state_n = P_WAIT_VAL;
                    end
                    P_WAIT_VAL: begin
                        exec    = 1'b1;
                        state_n = P_WAIT_KEY;
                    end
                    default: state_n = P_IDLE;
                endcase
            end
        end
    end

    // Translate a completed message into a stack operation
    always_comb begin
        push   = 1'b0;
        remove = 1'b0;
        clear  = 1'b0;
        if (exec) begin
            case (cmd)
                CMD_ON: begin
                    if (midi_data[6:0] != 7'd0) begin
                        push = 1'b1;
                    end else begin
                        remove = 1'b1;
                    end
                end
                CMD_OFF: remove = 1'b1;
                CMD_CC: begin
                    if (key_reg == CC_ALL_SOUND_OFF || key_reg == CC_ALL_NOTES_OFF) begin
                        clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    note_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .remove (remove),
        .clear  (clear),
        .key    (key_reg),
        .top    (top),
        .count  (held_count),
        .full   (full),
        .hit    (hit)
    );

    // Output scheduler looks at the stack as it stood before this edge; overflow is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_data  <= '0;
            note_valid <= 1'b0;
            gate       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (held_count != 5'd0 && (!gate || top != note_data[6:0])) begin
                note_data  <= {1'b0, top};
                note_valid <= 1'b1;
            end else begin
                note_valid <= 1'b0;
            end
            gate <= (held_count != 5'd0);
            if (push && full && !hit) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
